// File: rtl/inst_ram_arb_pkg.sv
// Shared types and default widths for the instruction RAM arbiter.
// Optional perf counters are enabled with INST_RAM_ARB_PERF_EN.
package inst_ram_arb_pkg;

    localparam int unsigned DEF_ADDR_W        = 12;
    localparam int unsigned DEF_DATA_W        = 32;
    localparam int unsigned DEF_MAX_DBG_BURST = 4;
    localparam int unsigned PERF_CNT_W        = 32;

    // Owner of the access whose read data returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage : inst_ram_arb_pkg

// File: rtl/inst_ram_arbiter_if.sv
// Bundle between the IF stage, the debug loader, the instruction RAM and the arbiter.
// slave is the arbiter's view; master is the requesters' and RAM's view.
interface inst_ram_arbiter_if
    import inst_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_stall;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dbg_req;
    logic [BE_W-1:0]   dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_halt;
    logic              dbg_gnt;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [BE_W-1:0]   ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [DATA_W-1:0] ram_dina;
    logic [DATA_W-1:0] ram_douta;

    modport slave (
        input  if_req, if_addr,
        output if_stall, if_rvalid, if_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output dbg_gnt, dbg_ack, dbg_rdata,
        output ram_wea, ram_addra, ram_dina,
        input  ram_douta
    );

    modport master (
        output if_req, if_addr,
        input  if_stall, if_rvalid, if_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  dbg_gnt, dbg_ack, dbg_rdata,
        input  ram_wea, ram_addra, ram_dina,
        output ram_douta
    );

endinterface : inst_ram_arbiter_if

// File: rtl/inst_ram_arb_perf.sv
// Utilisation counters for the instruction RAM arbiter; wrap at 2^32, clear on rst.
// Compiled only when INST_RAM_ARB_PERF_EN is defined.
`ifdef INST_RAM_ARB_PERF_EN
module inst_ram_arb_perf
    import inst_ram_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_stall,
    input  logic                  dbg_gnt,
    input  logic                  if_gnt,
    output logic [PERF_CNT_W-1:0] perf_if_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_dbg_cnt,
    output logic [PERF_CNT_W-1:0] perf_if_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_cnt <= '0;
            perf_dbg_cnt      <= '0;
            perf_if_cnt       <= '0;
        end else begin
            perf_if_stall_cnt <= perf_if_stall_cnt + PERF_CNT_W'(if_stall);
            perf_dbg_cnt      <= perf_dbg_cnt + PERF_CNT_W'(dbg_gnt);
            perf_if_cnt       <= perf_if_cnt + PERF_CNT_W'(if_gnt);
        end
    end

endmodule : inst_ram_arb_perf
`endif

// File: rtl/inst_ram_arbiter.sv
// Shares the instruction RAM port between IF fetch and the debug loader, routing read data back.
// Define INST_RAM_ARB_PERF_EN to add the perf_* counter outputs.
module inst_ram_arbiter
    import inst_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned MAX_DBG_BURST = DEF_MAX_DBG_BURST
) (
    input  logic clk,
    input  logic rst,
    inst_ram_arbiter_if.slave bus
`ifdef INST_RAM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_if_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_dbg_cnt,
    output logic [PERF_CNT_W-1:0] perf_if_cnt
`endif
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(MAX_DBG_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DBG_BURST);

    logic              fetch_wait;
    logic              dbg_gnt;
    logic              if_gnt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   ram_wea_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_din_c;
    owner_e            resp_owner;
    owner_e            resp_owner_nxt;

    // A fetch that could be served this cycle; debug only yields to it once the burst is spent.
    assign fetch_wait = bus.if_req && !bus.dbg_halt;

    always_comb begin : grant
        dbg_gnt = 1'b0;
        if_gnt  = 1'b0;
        if (!rst) begin
            if (bus.dbg_req && (!fetch_wait || (burst_cnt < BURST_MAX))) begin
                dbg_gnt = 1'b1;
            end else if (fetch_wait) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign bus.dbg_gnt  = dbg_gnt;
    assign bus.if_stall = !rst && bus.if_req && !if_gnt;

    always_comb begin : burst_next
        burst_cnt_nxt = burst_cnt;
        if (!fetch_wait || if_gnt) begin
            burst_cnt_nxt = '0;
        end else if (dbg_gnt && (burst_cnt < BURST_MAX)) begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin : burst_reg
        if (rst) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // With no grant the address is parked on its last value; data and enables drop to zero.
    always_comb begin : ram_drive
        ram_wea_c  = '0;
        ram_addr_c = addr_q;
        ram_din_c  = '0;
        if (rst) begin
            ram_addr_c = '0;
        end else if (dbg_gnt) begin
            ram_wea_c  = bus.dbg_we;
            ram_addr_c = bus.dbg_addr;
            ram_din_c  = bus.dbg_wdata;
        end else if (if_gnt) begin
            ram_addr_c = bus.if_addr;
        end
    end

    always_ff @(posedge clk) begin : addr_reg
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= ram_addr_c;
        end
    end

    assign bus.ram_wea   = ram_wea_c;
    assign bus.ram_addra = ram_addr_c;
    assign bus.ram_dina  = ram_din_c;

    always_ff @(posedge clk) begin : resp_state
        if (rst) begin
            resp_owner <= OWN_NONE;
        end else begin
            resp_owner <= resp_owner_nxt;
        end
    end

    always_comb begin : resp_next
        resp_owner_nxt = OWN_NONE;
        if (dbg_gnt) begin
            resp_owner_nxt = OWN_DBG;
        end else if (if_gnt) begin
            resp_owner_nxt = OWN_IF;
        end
    end

    // Read data is steered to the owner only; a response pending across reset is dropped.
    always_comb begin : resp_out
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dbg_ack   = 1'b0;
        bus.dbg_rdata = '0;
        if (!rst) begin
            case (resp_owner)
                OWN_IF: begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.ram_douta;
                end
                OWN_DBG: begin
                    bus.dbg_ack   = 1'b1;
                    bus.dbg_rdata = bus.ram_douta;
                end
                default: ;
            endcase
        end
    end

`ifdef INST_RAM_ARB_PERF_EN
    inst_ram_arb_perf u_perf (
        .clk               (clk),
        .rst               (rst),
        .if_stall          (bus.if_stall),
        .dbg_gnt           (dbg_gnt),
        .if_gnt            (if_gnt),
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_dbg_cnt      (perf_dbg_cnt),
        .perf_if_cnt       (perf_if_cnt)
    );
`endif

    a_one_grant : assert property (@(posedge clk) disable iff (rst) !(dbg_gnt && if_gnt));
    a_write_dbg : assert property (@(posedge clk) disable iff (rst) (ram_wea_c != '0) |-> dbg_gnt);
    a_halt_blk  : assert property (@(posedge clk) disable iff (rst) bus.dbg_halt |-> !if_gnt);
    a_burst_max : assert property (@(posedge clk) disable iff (rst) burst_cnt <= BURST_MAX);

endmodule : inst_ram_arbiter

// File: tb/tb_inst_ram_arbiter.sv
// Scoreboarded bench for inst_ram_arbiter with a behavioural read-before-write RAM.
// Define INST_RAM_ARB_PERF_EN to also exercise the perf counters.
module tb_inst_ram_arbiter;
    import inst_ram_arb_pkg::*;

    localparam int unsigned AW = DEF_ADDR_W;
    localparam int unsigned DW = DEF_DATA_W;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) tb_if ();

`ifdef INST_RAM_ARB_PERF_EN
    logic [31:0] perf_if_stall_cnt, perf_dbg_cnt, perf_if_cnt;
`endif

    inst_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DBG_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
`ifdef INST_RAM_ARB_PERF_EN
        ,
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_dbg_cnt      (perf_dbg_cnt),
        .perf_if_cnt       (perf_if_cnt)
`endif
    );

    // RAM: word i holds 0x1000_0000|i, word 5 holds 0x11223344; reloaded while rst is high.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] wr_word;
    always @(posedge clk) begin
        if (rst) begin
            tb_if.ram_douta <= '0;
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h1000_0000 | DW'(i);
            mem[5] <= 32'h1122_3344;
        end else begin
            tb_if.ram_douta <= mem[tb_if.ram_addra];
            wr_word = mem[tb_if.ram_addra];
            for (int b = 0; b < BW; b++)
                if (tb_if.ram_wea[b]) wr_word[8*b +: 8] = tb_if.ram_dina[8*b +: 8];
            mem[tb_if.ram_addra] <= wr_word;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_dbg[$];

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        tb_if.if_req    = 1'b0;
        tb_if.if_addr   = '0;
        tb_if.dbg_req   = 1'b0;
        tb_if.dbg_we    = '0;
        tb_if.dbg_addr  = '0;
        tb_if.dbg_wdata = '0;
        tb_if.dbg_halt  = 1'b0;
    endtask

    task automatic test_reset;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                rst = 1'b1;
                tb_if.if_req = 1'b1; tb_if.if_addr = 12'h003;
                tb_if.dbg_req = 1'b1; tb_if.dbg_we = '1; tb_if.dbg_addr = 12'h008;
                tb_if.dbg_wdata = 32'hDEAD_BEEF;
                next_cycle();
            end else begin
                rst = 1'b0;
                drive_idle();
            end
            #1;
            n_checks++;
            if ({tb_if.if_stall, tb_if.dbg_gnt, tb_if.if_rvalid, tb_if.dbg_ack} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_ctl ph=%0d stall/gnt/rvalid/ack=%b%b%b%b expected 0000", ph,
                         tb_if.if_stall, tb_if.dbg_gnt, tb_if.if_rvalid, tb_if.dbg_ack);
            end
            n_checks++;
            if ({tb_if.if_rdata, tb_if.dbg_rdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_rdata ph=%0d if_rdata=%h dbg_rdata=%h expected 0", ph,
                         tb_if.if_rdata, tb_if.dbg_rdata);
            end
            n_checks++;
            if ({tb_if.ram_wea, tb_if.ram_addra, tb_if.ram_dina} !== '0) begin
                n_fail++;
                $display("FAIL reset_ram ph=%0d wea=%h addra=%h dina=%h expected 0", ph,
                         tb_if.ram_wea, tb_if.ram_addra, tb_if.ram_dina);
            end
        end
        next_cycle();
    endtask

    task automatic test_fetch;
        logic pend_if = 1'b0;
        logic [DW-1:0] e;
        for (int k = 0; k < 5; k++) begin
            tb_if.if_req  = (k < 3);
            tb_if.if_addr = AW'(k);
            #1;
            n_checks++;
            if (tb_if.if_rvalid !== pend_if || tb_if.dbg_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_pulse cyc=%0d if_rvalid=%b dbg_ack=%b expected %b/0", k,
                         tb_if.if_rvalid, tb_if.dbg_ack, pend_if);
            end
            if (tb_if.if_rvalid === 1'b1 && exp_if.size() > 0) begin
                e = exp_if.pop_front();
                n_checks++;
                if (tb_if.if_rdata !== e) begin
                    n_fail++;
                    $display("FAIL fetch_data cyc=%0d got=%h expected=%h", k, tb_if.if_rdata, e);
                end
            end else begin
                n_checks++;
                if (tb_if.if_rdata !== '0) begin
                    n_fail++;
                    $display("FAIL fetch_rdata_idle cyc=%0d got=%h expected 0", k, tb_if.if_rdata);
                end
            end
            n_checks++;
            if (tb_if.if_stall !== 1'b0 || tb_if.ram_wea !== '0 || tb_if.ram_addra !== AW'(k < 3 ? k : 2)) begin
                n_fail++;
                $display("FAIL fetch_drive cyc=%0d stall=%b wea=%h addra=%h expected 0/0/%0d", k,
                         tb_if.if_stall, tb_if.ram_wea, tb_if.ram_addra, (k < 3 ? k : 2));
            end
            if (k < 3) exp_if.push_back(32'h1000_0000 | DW'(k));
            pend_if = (k < 3);
            next_cycle();
        end
        drive_idle();
        n_checks++;
        if (exp_if.size() != 0) begin
            n_fail++;
            $display("FAIL fetch_missing got=%0d outstanding expected 0", exp_if.size());
        end
    endtask

    task automatic test_dbg_write_read;
        logic pend_dbg = 1'b0;
        logic [DW-1:0] e;
        for (int k = 0; k < 4; k++) begin
            tb_if.dbg_req   = (k < 2);
            tb_if.dbg_we    = (k == 0) ? 4'b0011 : 4'b0000;
            tb_if.dbg_addr  = 12'h005;
            tb_if.dbg_wdata = 32'hAABB_CCDD;
            #1;
            n_checks++;
            if (tb_if.dbg_ack !== pend_dbg || tb_if.if_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL dbg_pulse cyc=%0d dbg_ack=%b if_rvalid=%b expected %b/0", k,
                         tb_if.dbg_ack, tb_if.if_rvalid, pend_dbg);
            end
            if (tb_if.dbg_ack === 1'b1 && exp_dbg.size() > 0) begin
                e = exp_dbg.pop_front();
                n_checks++;
                if (tb_if.dbg_rdata !== e) begin
                    n_fail++;
                    $display("FAIL dbg_data cyc=%0d got=%h expected=%h", k, tb_if.dbg_rdata, e);
                end
            end else begin
                n_checks++;
                if (tb_if.dbg_rdata !== '0) begin
                    n_fail++;
                    $display("FAIL dbg_rdata_idle cyc=%0d got=%h expected 0", k, tb_if.dbg_rdata);
                end
            end
            n_checks++;
            if (tb_if.dbg_gnt !== (k < 2) || tb_if.ram_wea !== ((k == 0) ? 4'b0011 : 4'b0000)) begin
                n_fail++;
                $display("FAIL dbg_grant cyc=%0d gnt=%b wea=%h expected %b/%h", k, tb_if.dbg_gnt,
                         tb_if.ram_wea, (k < 2), ((k == 0) ? 4'b0011 : 4'b0000));
            end
            if (k < 2) begin
                n_checks++;
                if (tb_if.ram_addra !== 12'h005 || tb_if.ram_dina !== 32'hAABB_CCDD) begin
                    n_fail++;
                    $display("FAIL dbg_ram cyc=%0d addra=%h dina=%h expected 005/aabbccdd", k,
                             tb_if.ram_addra, tb_if.ram_dina);
                end
                exp_dbg.push_back((k == 0) ? 32'h1122_3344 : 32'h1122_CCDD);
            end
            pend_dbg = (k < 2);
            next_cycle();
        end
        drive_idle();
        n_checks++;
        if (exp_dbg.size() != 0) begin
            n_fail++;
            $display("FAIL dbg_missing got=%0d outstanding expected 0", exp_dbg.size());
        end
    endtask

    task automatic test_contention;
        logic pend_if = 1'b0, pend_dbg = 1'b0, d;
        logic [DW-1:0] e;
        for (int k = 0; k < 12; k++) begin
            tb_if.if_req = (k < 10); tb_if.if_addr = 12'h007;
            tb_if.dbg_req = (k < 10); tb_if.dbg_addr = 12'h009; tb_if.dbg_we = '0;
            d = (k < 10) && ((k % 5) != 4);
            #1;
            n_checks++;
            if (tb_if.if_rvalid !== pend_if || tb_if.dbg_ack !== pend_dbg) begin
                n_fail++;
                $display("FAIL cont_pulse cyc=%0d rvalid/ack=%b/%b expected %b/%b", k,
                         tb_if.if_rvalid, tb_if.dbg_ack, pend_if, pend_dbg);
            end
            if (tb_if.if_rvalid === 1'b1 && exp_if.size() > 0) begin
                e = exp_if.pop_front();
                n_checks++;
                if (tb_if.if_rdata !== e) begin
                    n_fail++;
                    $display("FAIL cont_if_data cyc=%0d got=%h expected=%h", k, tb_if.if_rdata, e);
                end
            end
            if (tb_if.dbg_ack === 1'b1 && exp_dbg.size() > 0) begin
                e = exp_dbg.pop_front();
                n_checks++;
                if (tb_if.dbg_rdata !== e) begin
                    n_fail++;
                    $display("FAIL cont_dbg_data cyc=%0d got=%h expected=%h", k, tb_if.dbg_rdata, e);
                end
            end
            if (k < 10) begin
                n_checks++;
                if (tb_if.dbg_gnt !== d || tb_if.if_stall !== d || tb_if.ram_addra !== (d ? 12'h009 : 12'h007)) begin
                    n_fail++;
                    $display("FAIL cont_grant cyc=%0d gnt=%b stall=%b addra=%h expected %b/%b/%h", k,
                             tb_if.dbg_gnt, tb_if.if_stall, tb_if.ram_addra, d, d, (d ? 12'h009 : 12'h007));
                end
                if (d) exp_dbg.push_back(32'h1000_0009);
                else   exp_if.push_back(32'h1000_0007);
            end
            pend_dbg = d;
            pend_if  = (k < 10) && !d;
            next_cycle();
        end
        drive_idle();
        n_checks++;
        if (exp_if.size() != 0 || exp_dbg.size() != 0) begin
            n_fail++;
            $display("FAIL cont_missing got=%0d/%0d outstanding expected 0/0", exp_if.size(), exp_dbg.size());
        end
    endtask

    task automatic test_halt;
        logic pend_if = 1'b0, pend_dbg = 1'b0, ed, ef, es;
        logic [DW-1:0] e;
        for (int k = 0; k < 13; k++) begin
            tb_if.dbg_halt = (k < 10) || (k == 11);
            tb_if.if_req   = (k <= 11); tb_if.if_addr = 12'h003;
            tb_if.dbg_req  = (k >= 2) && (k <= 7); tb_if.dbg_addr = 12'h005; tb_if.dbg_we = '0;
            ed = (k >= 2) && (k <= 7);
            ef = (k == 10);
            es = (k <= 11) && !ef;
            #1;
            n_checks++;
            if (tb_if.if_rvalid !== pend_if || tb_if.dbg_ack !== pend_dbg) begin
                n_fail++;
                $display("FAIL halt_pulse cyc=%0d rvalid/ack=%b/%b expected %b/%b", k,
                         tb_if.if_rvalid, tb_if.dbg_ack, pend_if, pend_dbg);
            end
            if (tb_if.if_rvalid === 1'b1 && exp_if.size() > 0) begin
                e = exp_if.pop_front();
                n_checks++;
                if (tb_if.if_rdata !== e) begin
                    n_fail++;
                    $display("FAIL halt_if_data cyc=%0d got=%h expected=%h", k, tb_if.if_rdata, e);
                end
            end
            if (tb_if.dbg_ack === 1'b1 && exp_dbg.size() > 0) begin
                e = exp_dbg.pop_front();
                n_checks++;
                if (tb_if.dbg_rdata !== e) begin
                    n_fail++;
                    $display("FAIL halt_dbg_data cyc=%0d got=%h expected=%h", k, tb_if.dbg_rdata, e);
                end
            end
            n_checks++;
            if (tb_if.dbg_gnt !== ed || tb_if.if_stall !== es || tb_if.ram_wea !== '0) begin
                n_fail++;
                $display("FAIL halt_grant cyc=%0d gnt=%b stall=%b wea=%h expected %b/%b/0", k,
                         tb_if.dbg_gnt, tb_if.if_stall, tb_if.ram_wea, ed, es);
            end
            if (ed) exp_dbg.push_back(32'h1122_CCDD);
            if (ef) exp_if.push_back(32'h1000_0003);
            pend_dbg = ed;
            pend_if  = ef;
            next_cycle();
        end
        drive_idle();
        n_checks++;
        if (exp_if.size() != 0 || exp_dbg.size() != 0) begin
            n_fail++;
            $display("FAIL halt_missing got=%0d/%0d outstanding expected 0/0", exp_if.size(), exp_dbg.size());
        end
    endtask

    task automatic test_reset_mid;
        logic pend_if = 1'b0, pend_dbg = 1'b0, r, ed, ef;
        logic [DW-1:0] e;
        for (int k = 0; k < 11; k++) begin
            r = (k == 1) || (k == 7);
            rst = r;
            tb_if.if_req   = (k <= 1) || ((k >= 3) && (k <= 8));
            tb_if.if_addr  = (k == 0) ? 12'h004 : 12'h007;
            tb_if.dbg_req  = (k >= 1) && (k <= 8) && (k != 2);
            tb_if.dbg_we   = r ? '1 : '0;
            tb_if.dbg_addr = 12'h009; tb_if.dbg_wdata = 32'h5A5A_5A5A;
            ed = ((k >= 3) && (k <= 6)) || (k == 8);
            ef = (k == 0);
            #1;
            n_checks++;
            if (tb_if.if_rvalid !== pend_if || tb_if.dbg_ack !== pend_dbg) begin
                n_fail++;
                $display("FAIL rstmid_pulse cyc=%0d rvalid/ack=%b/%b expected %b/%b", k,
                         tb_if.if_rvalid, tb_if.dbg_ack, pend_if, pend_dbg);
            end
            if (tb_if.dbg_ack === 1'b1 && exp_dbg.size() > 0) begin
                e = exp_dbg.pop_front();
                n_checks++;
                if (tb_if.dbg_rdata !== e) begin
                    n_fail++;
                    $display("FAIL rstmid_dbg_data cyc=%0d got=%h expected=%h", k, tb_if.dbg_rdata, e);
                end
            end
            n_checks++;
            if (tb_if.dbg_gnt !== ed || tb_if.if_stall !== (tb_if.if_req && !r && !ef)) begin
                n_fail++;
                $display("FAIL rstmid_grant cyc=%0d gnt=%b stall=%b expected %b/%b", k,
                         tb_if.dbg_gnt, tb_if.if_stall, ed, (tb_if.if_req && !r && !ef));
            end
            if (r) begin
                n_checks++;
                if ({tb_if.ram_wea, tb_if.ram_addra, tb_if.ram_dina, tb_if.if_rdata, tb_if.dbg_rdata} !== '0) begin
                    n_fail++;
                    $display("FAIL rstmid_zero cyc=%0d wea=%h addra=%h dina=%h expected 0", k,
                             tb_if.ram_wea, tb_if.ram_addra, tb_if.ram_dina);
                end
            end
            if (ed && k != 6) exp_dbg.push_back(32'h1000_0009);
            pend_dbg = ed && (k != 6);
            pend_if  = 1'b0;
            next_cycle();
        end
        rst = 1'b0;
        drive_idle();
        n_checks++;
        if (exp_dbg.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_missing got=%0d outstanding expected 0", exp_dbg.size());
        end
    endtask

`ifdef INST_RAM_ARB_PERF_EN
    task automatic test_perf;
        rst = 1'b1;
        drive_idle();
        next_cycle();
        rst = 1'b0;
        tb_if.if_req = 1'b1; tb_if.if_addr = 12'h007;
        tb_if.dbg_req = 1'b1; tb_if.dbg_addr = 12'h009;
        repeat (10) next_cycle();
        drive_idle();
        repeat (2) next_cycle();
        n_checks++;
        if (perf_dbg_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL perf_dbg got=%0d expected 8", perf_dbg_cnt);
        end
        n_checks++;
        if (perf_if_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_if got=%0d expected 2", perf_if_cnt);
        end
        n_checks++;
        if (perf_if_stall_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL perf_stall got=%0d expected 8", perf_if_stall_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_fetch();
        test_dbg_write_read();
        test_contention();
        test_halt();
        test_reset_mid();
`ifdef INST_RAM_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_ram_arbiter
